data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one RV32I data access, waits WAIT_CYCLES, then answers from a word RAM.
// Define MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of force-aligning them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic        r_load_ok;
  logic [31:0] r_rword;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_enter_resp;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [2:0]    w_acc_f3;
  logic          w_bad_f3;
  logic          w_oob;
  logic          w_misalign;
  logic          w_err;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [7:0]    w_rbyte;
  logic [15:0]   w_rhalf;
  logic [31:0]   w_ext;

  // With zero wait states the access happens on the accept edge, before the request is registered.
  assign w_acc_we    = (r_state == IDLE) ? req_we     : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_acc_f3    = (r_state == IDLE) ? req_funct3 : r_funct3;

  assign w_enter_resp = ((r_state == WAIT) && (r_cnt == 4'd0)) ||
                        ((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0));

  assign w_bad_f3 = (w_acc_f3 == 3'b011) || (w_acc_f3[2:1] == 2'b11) || (w_acc_we && w_acc_f3[2]);
  assign w_oob    = |w_acc_addr[31:AW+2];
`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((w_acc_f3[1:0] == 2'b01) && w_acc_addr[0]) ||
                      ((w_acc_f3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err    = w_bad_f3 || w_oob || w_misalign;
  assign w_commit = w_enter_resp && w_acc_we && !w_err;
  assign w_idx    = w_acc_addr[AW+1:2];

  always_comb begin
    w_lane   = 2'b00;
    w_be     = 4'b1111;
    w_wlanes = w_acc_wdata;
    case (w_acc_f3[1:0])
      2'b00: begin
        w_lane   = w_acc_addr[1:0];
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_lane   = {w_acc_addr[1], 1'b0};
        w_be     = 4'b0011 << w_lane;
        w_wlanes = {2{w_acc_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_commit && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
    end
    if (w_enter_resp) r_rword <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= '0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_err     <= w_err;
        r_load_ok <= !w_acc_we && !w_err;
      end
    end
  end

  always_comb begin
    w_rbyte = r_rword[{r_addr[1:0], 3'b000} +: 8];
    w_rhalf = r_addr[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_rbyte[7]}}, w_rbyte};
      3'b100:  w_ext = {24'd0, w_rbyte};
      3'b001:  w_ext = {{16{w_rhalf[15]}}, w_rhalf};
      3'b101:  w_ext = {16'd0, w_rhalf};
      default: w_ext = r_rword;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_load_ok ? w_ext : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized + directed bench for data_mem_responder against an arithmetic model of the memory.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_mem [DEPTH];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-lane model: size = 1<<funct3[1:0] bytes, offset rounded down to the size.
  function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic [2:0] f3, output logic err, output logic [31:0] rd);
    int unsigned idx, off, nbytes;
    logic [31:0] w, val, mask;
    err = 1'b0;
    rd  = 32'd0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
    if (a >= 32'(4 * DEPTH)) err = 1'b1;
    nbytes = 1 << f3[1:0];
    off    = a % 4;
`ifdef MISALIGN_TRAP_EN
    if (off % nbytes != 0) err = 1'b1;
`endif
    if (err) return;
    off  = off - (off % nbytes);
    idx  = a / 4;
    w    = model_mem[idx];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (we) begin
      model_mem[idx] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    end else begin
      val = (w >> (8 * off)) & mask;
      if (f3 < 3'd4 && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
      rd = val;
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, input string tag,
                        output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] held_rd;
    logic        held_err;
    int          lat;
    model(we, a, wd, f3, exp_err, exp_rd);
    @(negedge clk);
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(W + 1));
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
    got      = rsp_rdata;
    held_rd  = rsp_rdata;
    held_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, held_rd);
      check({tag, "/hold_err"}, 32'(rsp_err), 32'(held_err));
      check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    // A harmless load is offered during the handshake cycle; it must not be taken on that edge.
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "/done_ready"}, 32'(req_ready), 32'd1);
    $display("req %s we=%0b addr=%h wdata=%h f3=%0d -> rdata=%h err=%0b lat=%0d",
             tag, we, a, wd, f3, got, held_err, lat);
  endtask

  initial begin
    logic [31:0] got;
    logic        rwe;
    logic [31:0] raddr;
    logic [2:0]  rf3;
    int          lat;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst/ready", 32'(req_ready), 32'd1);
    check("rst/valid", 32'(rsp_valid), 32'd0);
    check("rst/rdata", rsp_rdata, 32'd0);
    check("rst/err", 32'(rsp_err), 32'd0);
    rst = 1'b1;

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, "sw10", got);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, "lw10", got);
    check("lw10/const", got, 32'hDEADBEEF);
    do_req(1'b1, 32'h11, 32'h80, 3'b000, 0, "sb11", got);
    do_req(1'b0, 32'h11, 32'h0, 3'b000, 0, "lb11", got);
    check("lb11/const", got, 32'hFFFFFF80);
    do_req(1'b0, 32'h11, 32'h0, 3'b100, 0, "lbu11", got);
    check("lbu11/const", got, 32'h00000080);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 5, "lw10_hold", got);
    check("lw10b/const", got, 32'hDEAD80EF);

    do_req(1'b1, 32'h0, 32'hA5A5A5A5, 3'b010, 0, "sw0", got);
    do_req(1'b1, 32'h1000, 32'h11112222, 3'b010, 0, "sw_oob", got);
    do_req(1'b0, 32'h0, 32'h0, 3'b010, 0, "lw0", got);
    check("lw0/const", got, 32'hA5A5A5A5);
    do_req(1'b0, 32'h10, 32'h0, 3'b011, 1, "f3_011", got);

    do_req(1'b1, 32'h20, 32'h12345678, 3'b010, 0, "sw20", got);
    do_req(1'b0, 32'h21, 32'h0, 3'b001, 0, "lh21", got);
`ifdef MISALIGN_TRAP_EN
    check("lh21/const", got, 32'h0);
`else
    check("lh21/const", got, 32'h00005678);
`endif

    // Reset while a store waits: the store must not land.
    do_req(1'b1, 32'h30, 32'h1, 3'b010, 0, "sw30", got);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort/in_wait", 32'(req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort/ready", 32'(req_ready), 32'd1);
    check("abort/valid", 32'(rsp_valid), 32'd0);
    check("abort/rdata", rsp_rdata, 32'd0);
    check("abort/err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("req abort sw30 wdata=00000055 by reset in WAIT");
    do_req(1'b0, 32'h30, 32'h0, 3'b010, 0, "lw30", got);
    check("lw30/const", got, 32'h1);

    // Reset while a load response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("drop/latency", 32'(lat), 32'(W + 1));
    #2 rst = 1'b0;
    #1;
    check("drop/valid", 32'(rsp_valid), 32'd0);
    check("drop/rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("req drop lw10 response by reset in RESP");

    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 32'h40 + 32'(4 * i), $urandom, 3'b010, 0, "fill", got);
    end
    for (int i = 0; i < 60; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = 32'h40 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) raddr = 32'h1000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) raddr = $urandom | 32'h8000_0000;
      do_req(rwe, raddr, $urandom, rf3, $urandom_range(0, 2), "rand", got);
    end
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 32'h40 + 32'(4 * i), 32'h0, 3'b010, 0, "final", got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
